hw_info_scanner: RTL and testbench

Bus initiator that drives the 16-bit VME-style register port of the hardware-info block (standard version, serial number, firmware version, memory-map version, echo register). On a start request it reads all ten identification words, runs a two-pattern write/read-back test on the echo register, and publishes the collected values atomically with a valid flag. It sits next to the hardware-info responder and feeds local status logic, with no host software involved.

---
 rtl/hw_info_scanner.sv | 248 ++++++++++++++++++++++++
 tb/tb_hw_info_scanner.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_info_scanner.sv
// hw_info_scanner: reads the ten hardware-info words over the VME-style
// register port, runs an echo write/read-back test, publishes the result.
// Ports: Clk/rst_n, Start pulse; VMEAddr/VMEWrData/VMERdMem/VMEWrMem out,
// VMERdData/VMERdDone/VMEWrDone in; Busy/Valid/Error/ErrCode/ErrAddr
// status; stdVersion_o/serialNumber_o/firmwareVersion_o/memMapVersion_o.
module hw_info_scanner #(
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [7:0]  ECHO_PATTERN = 8'hA5
) (
  input  logic        Clk,
  input  logic        rst_n,
  input  logic        Start,
  output logic [4:1]  VMEAddr,
  output logic [15:0] VMEWrData,
  output logic        VMERdMem,
  output logic        VMEWrMem,
  input  logic [15:0] VMERdData,
  input  logic        VMERdDone,
  input  logic        VMEWrDone,
  output logic        Busy,
  output logic        Valid,
  output logic        Error,
  output logic [1:0]  ErrCode,
  output logic [4:1]  ErrAddr,
  output logic [31:0] stdVersion_o,
  output logic [63:0] serialNumber_o,
  output logic [31:0] firmwareVersion_o,
  output logic [31:0] memMapVersion_o
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ,
    WR_WAIT, CHECK, FINISH, ABORT
  } state_t;

  localparam logic [3:0] ECHO_ADDR = 4'hB;
  localparam logic [3:0] LAST_IDX  = 4'd9;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] PAT1      = ECHO_PATTERN;
  localparam logic [7:0] PAT2      = ~ECHO_PATTERN;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        echo_q, echo_d;
  logic        pat_q, pat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  rbyte_q, rbyte_d;
  logic [15:0] word_q [10];
  logic [15:0] word_d [10];
  logic [3:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [3:0]  eaddr_q, eaddr_d;
  logic [31:0] std_q, std_d;
  logic [63:0] ser_q, ser_d;
  logic [31:0] fw_q, fw_d;
  logic [31:0] mm_q, mm_d;

  logic [7:0] exp_byte;
  assign exp_byte = pat_q ? PAT2 : PAT1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    echo_d  = echo_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    rbyte_d = rbyte_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    busy_d  = busy_q;
    valid_d = valid_q;
    err_d   = err_q;
    code_d  = code_q;
    eaddr_d = eaddr_q;
    std_d   = std_q;
    ser_d   = ser_q;
    fw_d    = fw_q;
    mm_d    = mm_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          code_d  = 2'b00;
          eaddr_d = 4'h0;
          idx_d   = 4'd0;
          echo_d  = 1'b0;
          pat_d   = 1'b0;
          addr_d  = 4'd0;
          rd_d    = 1'b1;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        cnt_d   = 8'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (VMERdDone) begin
          if (echo_q) begin
            rbyte_d = VMERdData[7:0];
            state_d = CHECK;
          end else begin
            for (int i = 0; i < 10; i++)
              if (idx_q == 4'(i))
                word_d[i] = VMERdData;
            if (idx_q == LAST_IDX) begin
              echo_d  = 1'b1;
              addr_d  = ECHO_ADDR;
              wdata_d = {8'h00, PAT1};
              wr_d    = 1'b1;
              state_d = WR_REQ;
            end else begin
              idx_d   = idx_q + 4'd1;
              addr_d  = idx_q + 4'd1;
              rd_d    = 1'b1;
              state_d = RD_REQ;
            end
          end
        end else if (cnt_q == TO_LAST) begin
          code_d  = 2'b01;
          eaddr_d = addr_q;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_REQ: begin
        cnt_d   = 8'd0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        // Echo write acknowledged: read the same register back.
        if (VMEWrDone) begin
          rd_d    = 1'b1;
          state_d = RD_REQ;
        end else if (cnt_q == TO_LAST) begin
          code_d  = 2'b01;
          eaddr_d = addr_q;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CHECK: begin
        if (rbyte_q != exp_byte) begin
          code_d  = 2'b10;
          eaddr_d = ECHO_ADDR;
          state_d = ABORT;
        end else if (!pat_q) begin
          pat_d   = 1'b1;
          wdata_d = {8'h00, PAT2};
          wr_d    = 1'b1;
          state_d = WR_REQ;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        std_d   = {word_q[0], word_q[1]};
        ser_d   = {word_q[2], word_q[3],
                   word_q[4], word_q[5]};
        fw_d    = {word_q[6], word_q[7]};
        mm_d    = {word_q[8], word_q[9]};
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ABORT: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      echo_q  <= 1'b0;
      pat_q   <= 1'b0;
      cnt_q   <= '0;
      rbyte_q <= '0;
      for (int i = 0; i < 10; i++)
        word_q[i] <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      eaddr_q <= '0;
      std_q   <= '0;
      ser_q   <= '0;
      fw_q    <= '0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      echo_q  <= echo_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      rbyte_q <= rbyte_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      eaddr_q <= eaddr_d;
      std_q   <= std_d;
      ser_q   <= ser_d;
      fw_q    <= fw_d;
      mm_q    <= mm_d;
    end
  end

  assign VMEAddr           = addr_q;
  assign VMEWrData         = wdata_q;
  assign VMERdMem          = rd_q;
  assign VMEWrMem          = wr_q;
  assign Busy              = busy_q;
  assign Valid             = valid_q;
  assign Error             = err_q;
  assign ErrCode           = code_q;
  assign ErrAddr           = eaddr_q;
  assign stdVersion_o      = std_q;
  assign serialNumber_o    = ser_q;
  assign firmwareVersion_o = fw_q;
  assign memMapVersion_o   = mm_q;

endmodule

// File: tb/tb_hw_info_scanner.sv
// tb_hw_info_scanner: directed bench for hw_info_scanner with a
// negedge-driven responder model of the hardware-info register block.
module tb_hw_info_scanner;

  logic        Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [4:1]  VMEAddr;
  logic [15:0] VMEWrData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic [15:0] VMERdData = '0;
  logic        VMERdDone = 1'b0;
  logic        VMEWrDone = 1'b0;
  logic        Busy;
  logic        Valid;
  logic        Error;
  logic [1:0]  ErrCode;
  logic [4:1]  ErrAddr;
  logic [31:0] stdVersion_o;
  logic [63:0] serialNumber_o;
  logic [31:0] firmwareVersion_o;
  logic [31:0] memMapVersion_o;

  hw_info_scanner #(
    .TIMEOUT(16),
    .ECHO_PATTERN(8'hA5)
  ) dut (
    .Clk(Clk),
    .rst_n(rst_n),
    .Start(Start),
    .VMEAddr(VMEAddr),
    .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem),
    .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData),
    .VMERdDone(VMERdDone),
    .VMEWrDone(VMEWrDone),
    .Busy(Busy),
    .Valid(Valid),
    .Error(Error),
    .ErrCode(ErrCode),
    .ErrAddr(ErrAddr),
    .stdVersion_o(stdVersion_o),
    .serialNumber_o(serialNumber_o),
    .firmwareVersion_o(firmwareVersion_o),
    .memMapVersion_o(memMapVersion_o)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // responder knobs (written by tests only)
  logic [15:0] base = 16'h1000;
  logic        stuck = 1'b0;
  logic [3:0]  sup_addr = 4'hF;
  logic [3:0]  lat_addr = 4'hF;
  int          lat_val = 1;
  logic [3:0]  spur_addr = 4'hF;

  // responder state (written by responder only)
  int          rd_n = 0;
  int          wr_n = 0;
  int          rd_cd = 0;
  int          wr_cd = 0;
  logic        spur_pend = 1'b0;
  logic [3:0]  rd_a = '0;
  logic [15:0] wr_buf = '0;
  logic [15:0] echo_mem = '0;

  always @(negedge Clk) begin
    VMERdDone = 1'b0;
    VMEWrDone = 1'b0;
    if (!rst_n) begin
      rd_cd = 0;
      wr_cd = 0;
      spur_pend = 1'b0;
    end else begin
      if (spur_pend) begin
        VMEWrDone = 1'b1;
        spur_pend = 1'b0;
      end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          VMERdDone = 1'b1;
          if (rd_a == 4'hB)
            VMERdData = stuck ? (echo_mem & 16'hFFFE) : echo_mem;
          else
            VMERdData = base + {12'h000, rd_a};
        end
      end
      if (wr_cd > 0) begin
        wr_cd--;
        if (wr_cd == 0) begin
          VMEWrDone = 1'b1;
          echo_mem = wr_buf;
        end
      end
      if (VMERdMem) begin
        rd_n++;
        rd_a = VMEAddr;
        if (rd_a == sup_addr) rd_cd = 0;
        else if (rd_a == lat_addr) rd_cd = lat_val;
        else rd_cd = 1;
        if (rd_a == spur_addr) spur_pend = 1'b1;
      end
      if (VMEWrMem) begin
        wr_n++;
        wr_buf = VMEWrData;
        wr_cd = 2;
      end
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      Start = 1'b0;
      n++;
    end while (Busy && n < 200);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Valid !== 1'b0 || Error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got B=%b V=%b E=%b want 000", Busy, Valid, Error);
    end
    checks++;
    if (VMERdMem !== 1'b0 || VMEWrMem !== 1'b0 || VMEAddr !== 4'h0) begin
      errors++;
      $display("FAIL reset_bus: got rd=%b wr=%b a=%h want 0 0 0", VMERdMem, VMEWrMem, VMEAddr);
    end
    checks++;
    if (serialNumber_o !== 64'h0 || stdVersion_o !== 32'h0 || ErrCode !== 2'b00) begin
      errors++;
      $display("FAIL reset_info: got ser=%h std=%h code=%b want 0", serialNumber_o, stdVersion_o, ErrCode);
    end
    rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_nominal;
    int n;
    int r0, w0;
    base = 16'h1000;
    r0 = rd_n;
    w0 = wr_n;
    Start = 1'b1;
    wait_idle(n);
    checks++;
    if (n !== 34) begin
      errors++;
      $display("FAIL nom_cycles: got %0d want 34", n);
    end
    checks++;
    if (serialNumber_o !== 64'h1002100310041005) begin
      errors++;
      $display("FAIL nom_serial: got %h want 1002100310041005", serialNumber_o);
    end
    checks++;
    if (stdVersion_o !== 32'h10001001 || firmwareVersion_o !== 32'h10061007 || memMapVersion_o !== 32'h10081009) begin
      errors++;
      $display("FAIL nom_words: got %h %h %h want 10001001 10061007 10081009", stdVersion_o, firmwareVersion_o, memMapVersion_o);
    end
    checks++;
    if (Valid !== 1'b1 || Error !== 1'b0 || ErrCode !== 2'b00) begin
      errors++;
      $display("FAIL nom_status: got V=%b E=%b code=%b want 1 0 00", Valid, Error, ErrCode);
    end
    checks++;
    if (rd_n - r0 != 12 || wr_n - w0 != 2) begin
      errors++;
      $display("FAIL nom_strobes: got rd=%0d wr=%0d want 12 2", rd_n - r0, wr_n - w0);
    end
  endtask

  task automatic test_echo_stuck;
    int n;
    int r0, w0;
    base = 16'h2000;
    stuck = 1'b1;
    r0 = rd_n;
    w0 = wr_n;
    Start = 1'b1;
    wait_idle(n);
    checks++;
    if (n !== 28) begin
      errors++;
      $display("FAIL echo_cycles: got %0d want 28", n);
    end
    checks++;
    if (Error !== 1'b1 || ErrCode !== 2'b10 || ErrAddr !== 4'hB) begin
      errors++;
      $display("FAIL echo_err: got E=%b code=%b addr=%h want 1 10 b", Error, ErrCode, ErrAddr);
    end
    checks++;
    if (Valid !== 1'b1 || serialNumber_o !== 64'h1002100310041005) begin
      errors++;
      $display("FAIL echo_keep: got V=%b ser=%h want 1 1002100310041005", Valid, serialNumber_o);
    end
    repeat (5) @(negedge Clk);
    checks++;
    if (rd_n - r0 != 11 || wr_n - w0 != 1) begin
      errors++;
      $display("FAIL echo_strobes: got rd=%0d wr=%0d want 11 1", rd_n - r0, wr_n - w0);
    end
    stuck = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    int r0;
    base = 16'h2000;
    sup_addr = 4'h3;
    r0 = rd_n;
    Start = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      Start = 1'b0;
      n++;
    end while (!Error && n < 200);
    checks++;
    if (n !== 25) begin
      errors++;
      $display("FAIL to_cycles: got %0d want 25", n);
    end
    checks++;
    if (Busy !== 1'b0 || ErrCode !== 2'b01 || ErrAddr !== 4'h3) begin
      errors++;
      $display("FAIL to_err: got B=%b code=%b addr=%h want 0 01 3", Busy, ErrCode, ErrAddr);
    end
    checks++;
    if (Valid !== 1'b1 || rd_n - r0 != 4) begin
      errors++;
      $display("FAIL to_keep: got V=%b rd=%0d want 1 4", Valid, rd_n - r0);
    end
    sup_addr = 4'hF;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_done_at_timeout;
    int n;
    base = 16'h3000;
    lat_addr = 4'h3;
    lat_val = 16;
    Start = 1'b1;
    wait_idle(n);
    checks++;
    if (n !== 49) begin
      errors++;
      $display("FAIL late_cycles: got %0d want 49", n);
    end
    checks++;
    if (Valid !== 1'b1 || Error !== 1'b0 || ErrCode !== 2'b00) begin
      errors++;
      $display("FAIL late_status: got V=%b E=%b code=%b want 1 0 00", Valid, Error, ErrCode);
    end
    checks++;
    if (serialNumber_o !== 64'h3002300330043005) begin
      errors++;
      $display("FAIL late_serial: got %h want 3002300330043005", serialNumber_o);
    end
    lat_addr = 4'hF;
    lat_val = 1;
  endtask

  task automatic test_back_to_back;
    int n;
    int r0, w0, r1;
    base = 16'h4000;
    lat_addr = 4'h5;
    lat_val = 2;
    spur_addr = 4'h5;
    r0 = rd_n;
    w0 = wr_n;
    Start = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      Start = (n == 5) || (n == 34);
    end while (Busy && n < 200);
    Start = 1'b0;
    checks++;
    if (n !== 35) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d want 35", n);
    end
    checks++;
    if (stdVersion_o !== 32'h40004001 || memMapVersion_o !== 32'h40084009) begin
      errors++;
      $display("FAIL b2b_words: got %h %h want 40004001 40084009", stdVersion_o, memMapVersion_o);
    end
    checks++;
    if (rd_n - r0 != 12 || wr_n - w0 != 2 || Valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_strobes: got rd=%0d wr=%0d V=%b want 12 2 1", rd_n - r0, wr_n - w0, Valid);
    end
    r1 = rd_n;
    repeat (3) @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || rd_n != r1) begin
      errors++;
      $display("FAIL b2b_late_start: got B=%b rd=%0d want 0 0", Busy, rd_n - r1);
    end
    lat_addr = 4'hF;
    lat_val = 1;
    spur_addr = 4'hF;
  endtask

  task automatic test_reset_mid;
    int n;
    int r0;
    base = 16'h4000;
    Start = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      Start = 1'b0;
      n++;
    end while (!(VMERdMem && VMEAddr == 4'h6) && n < 100);
    checks++;
    if (n !== 13) begin
      errors++;
      $display("FAIL mid_addr6: got %0d want 13", n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Valid !== 1'b0 || VMERdMem !== 1'b0 || VMEAddr !== 4'h0) begin
      errors++;
      $display("FAIL mid_async: got B=%b V=%b rd=%b a=%h want 0 0 0 0", Busy, Valid, VMERdMem, VMEAddr);
    end
    checks++;
    if (serialNumber_o !== 64'h0 || stdVersion_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_info: got ser=%h std=%h want 0", serialNumber_o, stdVersion_o);
    end
    r0 = rd_n;
    repeat (3) @(negedge Clk);
    rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (rd_n != r0 || wr_n < 0) begin
      errors++;
      $display("FAIL mid_quiet: got %0d extra reads want 0", rd_n - r0);
    end
    base = 16'h5000;
    Start = 1'b1;
    wait_idle(n);
    checks++;
    if (n !== 34 || Valid !== 1'b1 || Error !== 1'b0) begin
      errors++;
      $display("FAIL mid_rescan: got n=%0d V=%b E=%b want 34 1 0", n, Valid, Error);
    end
    checks++;
    if (serialNumber_o !== 64'h5002500350045005) begin
      errors++;
      $display("FAIL mid_serial: got %h want 5002500350045005", serialNumber_o);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_echo_stuck();
    test_timeout();
    test_done_at_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
